// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch reset/NOP defaults, fetch state encoding
// and the PC increment helper.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  // Sequential PC step; wraps naturally at 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_perf_cnt.sv
// Fetch performance counters: valid IF/ID loads and bubble cycles.
// Both counters clear on rst and wrap at 2^32.
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc,
  input  logic        bubble_inc,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
);

  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q + {31'd0, fetch_inc};
    bubble_cnt_d = bubble_cnt_q + {31'd0, bubble_inc};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem handshake, stall hold buffer, redirect
// handling and the IF/ID register. Define FETCH_PERF_CNT_EN to add counters.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master imem,
  input  logic          stall,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic          if_id_valid,
  output logic [31:0]   if_id_pc,
  output logic [31:0]   if_id_pc4,
  output logic [31:0]   if_id_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   fetch_cnt,
  output logic [31:0]   bubble_cnt
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  buf_q, buf_d;
  logic         req_q, req_d;
  logic         valid_q, valid_d;
  logic [31:0]  id_pc_q, id_pc_d;
  logic [31:0]  id_pc4_q, id_pc4_d;
  logic [31:0]  instr_q, instr_d;
  logic         rsp_ok;
  logic         id_load;
  logic         id_bubble;

  // req_q is low in the first cycle after reset, so any response then is stale.
  assign rsp_ok = req_q & imem.imem_ready;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    buf_d     = buf_q;
    id_load   = 1'b0;
    id_bubble = 1'b0;
    if (redirect) begin
      pc_d      = redirect_pc & 32'hFFFF_FFFC;
      buf_d     = '0;
      id_bubble = 1'b1;
      state_d   = (state_q == S_REQ && req_q && !imem.imem_ready) ? S_DROP : S_REQ;
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (rsp_ok) begin
            if (!stall) begin
              id_load = 1'b1;
              pc_d    = next_pc(pc_q);
            end else begin
              buf_d   = imem.imem_rdata;
              state_d = S_HOLD;
            end
          end else if (!stall) begin
            id_bubble = 1'b1;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            id_load = 1'b1;
            pc_d    = next_pc(pc_q);
            state_d = S_REQ;
          end
        end
        S_DROP: begin
          id_bubble = 1'b1;
          if (imem.imem_ready) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end

    valid_d = valid_q;
    id_pc_d = id_pc_q;
    instr_d = instr_q;
    if (id_bubble) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (id_load) begin
      valid_d = 1'b1;
      id_pc_d = pc_q;
      instr_d = (state_q == S_HOLD) ? buf_q : imem.imem_rdata;
    end
    id_pc4_d = next_pc(id_pc_d);
    req_d    = (state_d == S_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      buf_q    <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      id_pc_q  <= '0;
      id_pc4_q <= 32'd4;
      instr_q  <= NOP_INSTR;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      buf_q    <= buf_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      id_pc_q  <= id_pc_d;
      id_pc4_q <= id_pc4_d;
      instr_q  <= instr_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign if_id_valid    = valid_q;
  assign if_id_pc       = id_pc_q;
  assign if_id_pc4      = id_pc4_q;
  assign if_id_instr    = instr_q;

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_cnt u_perf_cnt (
    .clk        (clk),
    .rst        (rst),
    .fetch_inc  (id_load),
    .bubble_inc (id_bubble),
    .fetch_cnt  (fetch_cnt),
    .bubble_cnt (bubble_cnt)
  );
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 32'h0000_3000, first fetch address after reset.
REQ-002 Parameter NOP_INSTR, 32'h0000_0013, instruction placed in IF/ID on bubble or flush (addi x0,x0,0).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 imem_req  output  1  instruction-memory request valid.
REQ-006 imem_addr  output  32  fetch address (current PC).
REQ-007 imem_ready  input  1  response valid; imem_rdata valid this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 stall  input  1  decode stage cannot accept; IF/ID must hold.
REQ-010 redirect  input  1  branch/jump taken; refetch from redirect_pc.
REQ-011 redirect_pc  input  32  redirect target, word-aligned.
REQ-012 if_id_valid  output  1  IF/ID holds a real instruction.
REQ-013 if_id_pc  output  32  PC of IF/ID instruction.
REQ-014 if_id_pc4  output  32  if_id_pc + 4, for JAL/JALR link.
REQ-015 if_id_instr  output  32  instruction word to decoder/immediate generator.

Function
REQ-016 States: S_REQ (request outstanding), S_HOLD (response buffered, stalled), S_DROP (discarding stale response).
REQ-017 S_REQ: imem_req=1, imem_addr=pc; addr stable until imem_ready.
REQ-018 S_REQ, imem_ready & !stall: IF/ID <= {1, pc, imem_rdata}; pc <= pc+4; stay S_REQ (one instr/cycle with zero-wait memory).
REQ-019 S_REQ, imem_ready & stall: imem_rdata into hold buffer; IF/ID unchanged; -> S_HOLD.
REQ-020 S_REQ, !imem_ready & !stall: IF/ID <= bubble (valid=0, instr=NOP_INSTR, pc unchanged).
REQ-021 S_REQ, !imem_ready & stall: IF/ID unchanged.
REQ-022 S_HOLD: imem_req=0; when !stall, IF/ID <= {1, pc, buffer}; pc <= pc+4; -> S_REQ.
REQ-023 S_DROP: imem_req=0; IF/ID bubble; on imem_ready discard data -> S_REQ.
REQ-024 redirect has priority over stall and imem_ready: pc <= redirect_pc; IF/ID bubble; buffer discarded.
REQ-025 redirect in S_REQ without imem_ready -> S_DROP; otherwise -> S_REQ.
REQ-026 if_id_pc4 = if_id_pc + 4, mod 2^32; pc increment wraps 32'hFFFF_FFFC -> 0.
REQ-027 redirect_pc[1:0] ignored (forced 2'b00).

Reset
REQ-028 rst held: state S_REQ, pc=RESET_PC, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0, buffer cleared.
REQ-029 imem_req=0 while rst=1; first request RESET_PC the cycle after rst deasserts.
REQ-030 rst mid-transaction: outstanding response ignored; no stale word reaches IF/ID.

Configuration
REQ-031 FETCH_PERF_CNT_EN defined: outputs fetch_cnt[31:0] (IF/ID loads with valid=1) and bubble_cnt[31:0] (bubble cycles), cleared by rst, wrapping.
REQ-032 FETCH_PERF_CNT_EN undefined: ports and counters absent; other behaviour identical.

Structure
REQ-033 Shared package cpu_pkg: RESET_PC and NOP_INSTR defaults, fetch state enum.
REQ-034 Sub-module fetch_perf_cnt holds both counters, instantiated only under FETCH_PERF_CNT_EN.

Verification
REQ-035 Reset, imem_ready=1 always, no stall: addrs 0x3000,0x3004,0x3008 on consecutive cycles; if_id_pc follows one cycle later, if_id_valid=1.
REQ-036 Response 0x00500093 with stall=1 for 3 cycles: IF/ID unchanged, imem_req=0 cycles 2-3; stall drops -> if_id_instr=0x00500093, next addr +4.
REQ-037 redirect=1, redirect_pc=0x3100, imem_ready=1 same cycle: data dropped, if_id_valid=0, next imem_addr=0x3100.
REQ-038 Memory latency 3, redirect in cycle 1 of wait: S_DROP, late word never in IF/ID, then request 0x3100.
REQ-039 rst asserted mid-S_HOLD: next cycle after release imem_addr=0x3000, if_id_instr=0x00000013, if_id_valid=0.
REQ-040 FETCH_PERF_CNT_EN: 10 fetches plus 4 bubbles -> fetch_cnt=10, bubble_cnt=4.
